operand_unpack: RTL and testbench

OPERAND_UNPACK -- requirements
Module: operand_unpack

---
 rtl/fpu_addsub_pkg.sv | 25 ++
 rtl/operand_unpack_if.sv | 36 +++
 rtl/ld_reg.sv | 15 +
 rtl/operand_classify.sv | 38 +++
 rtl/operand_unpack.sv | 116 +++++++++++
 tb/tb_operand_unpack.sv | 280 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fpu_addsub_pkg.sv
// Shared FP add/sub constants: precision widths, exponent all-ones, bias and
// the operand classification encoding.
package fpu_addsub_pkg;

  localparam int SP_W  = 32;
  localparam int SP_EW = 8;
  localparam int SP_SW = 23;
  localparam int DP_W  = 64;
  localparam int DP_EW = 11;
  localparam int DP_SW = 52;

  localparam logic [SP_EW-1:0] SP_EXP_ONES = '1;
  localparam logic [DP_EW-1:0] DP_EXP_ONES = '1;
  localparam int unsigned      SP_BIAS     = 127;
  localparam int unsigned      DP_BIAS     = 1023;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_t;

endpackage

// File: rtl/operand_unpack_if.sv
// Operand-pair in / unpacked-result out handshake bundle for operand_unpack.
interface operand_unpack_if #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
);
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  op_a_i;
  logic [W-1:0]  op_b_i;
  logic          op_i;
  logic          valid_o;
  logic          ready_i;
  logic          sign_lg_o;
  logic [EW-1:0] exp_lg_o;
  logic [EW-1:0] exp_diff_o;
  logic [SW:0]   sgf_lg_o;
  logic [SW:0]   sgf_sm_o;
  logic          eff_sub_o;
  logic          swap_o;
  logic          zero_o;
  logic          inf_o;
  logic          nan_o;

  modport slave (
    input  valid_i, op_a_i, op_b_i, op_i, ready_i,
    output ready_o, valid_o, sign_lg_o, exp_lg_o, exp_diff_o,
           sgf_lg_o, sgf_sm_o, eff_sub_o, swap_o, zero_o, inf_o, nan_o
  );

  modport master (
    output valid_i, op_a_i, op_b_i, op_i, ready_i,
    input  ready_o, valid_o, sign_lg_o, exp_lg_o, exp_diff_o,
           sgf_lg_o, sgf_sm_o, eff_sub_o, swap_o, zero_o, inf_o, nan_o
  );
endinterface

// File: rtl/ld_reg.sv
// Loadable register with asynchronous active-high reset to zero.
module ld_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/operand_classify.sv
// Combinational IEEE operand classifier; denormal handling selected by
// OPERAND_UNPACK_DENORM_EN (undefined: denormals flush to signed zero).
module operand_classify
  import fpu_addsub_pkg::*;
#(
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic [EW-1:0] exp_i,
  input  logic [SW-1:0] sgf_i,
  output cls_t          cls_o,
  output logic [SW:0]   sgf_o,
  output logic [EW-1:0] exp_eff_o
);
  logic exp_max, exp_zero, sgf_zero;

  assign exp_max  = &exp_i;
  assign exp_zero = ~|exp_i;
  assign sgf_zero = ~|sgf_i;

  always_comb begin
    cls_o     = CLS_NORMAL;
    sgf_o     = {~exp_zero, sgf_i};
    exp_eff_o = exp_i;
    if (exp_max) begin
      cls_o = sgf_zero ? CLS_INF : CLS_NAN;
    end else if (exp_zero) begin
`ifdef OPERAND_UNPACK_DENORM_EN
      // A zero exponent field scales like exponent 1 when aligning.
      exp_eff_o = {{(EW-1){1'b0}}, 1'b1};
      cls_o     = sgf_zero ? CLS_ZERO : CLS_DENORM;
`else
      cls_o = CLS_ZERO;
      sgf_o = '0;
`endif
    end
  end
endmodule

// File: rtl/operand_unpack.sv
// Two-stage FP add/sub operand unpack: classify, order by magnitude, flag
// specials. Denormal support via OPERAND_UNPACK_DENORM_EN.
module operand_unpack
  import fpu_addsub_pkg::*;
#(
  parameter int W  = SP_W,
  parameter int EW = SP_EW,
  parameter int SW = SP_SW
) (
  input logic             clk,
  input logic             rst,
  operand_unpack_if.slave bus
);
  localparam int S1W = 3 + 4*EW + 2*(SW+1) + 6;
  localparam int S2W = 1 + 2*EW + 2*(SW+1) + 5;

  logic s1_valid, s2_valid, s2_ready, ready, s1_load, s2_load;

  assign s2_ready    = !s2_valid || bus.ready_i;
  assign ready       = !s1_valid || s2_ready;
  assign s1_load     = bus.valid_i && ready;
  assign s2_load     = s1_valid && s2_ready;
  assign bus.ready_o = ready;
  assign bus.valid_o = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)          s2_valid <= 1'b1;
      else if (bus.ready_i) s2_valid <= 1'b0;
    end
  end

  // Stage 1: classify each operand and compare raw magnitudes
  cls_t          cls_a, cls_b;
  logic [SW:0]   sgf_a, sgf_b;
  logic [EW-1:0] expe_a, expe_b;
  logic          swap_c;
  logic [S1W-1:0] s1_d, s1_q;

  operand_classify #(.EW(EW), .SW(SW)) u_cls_a (
    .exp_i     (bus.op_a_i[W-2 -: EW]),
    .sgf_i     (bus.op_a_i[SW-1:0]),
    .cls_o     (cls_a),
    .sgf_o     (sgf_a),
    .exp_eff_o (expe_a)
  );

  operand_classify #(.EW(EW), .SW(SW)) u_cls_b (
    .exp_i     (bus.op_b_i[W-2 -: EW]),
    .sgf_i     (bus.op_b_i[SW-1:0]),
    .cls_o     (cls_b),
    .sgf_o     (sgf_b),
    .exp_eff_o (expe_b)
  );

  assign swap_c = bus.op_b_i[W-2:0] > bus.op_a_i[W-2:0];
  assign s1_d   = {swap_c, bus.op_a_i[W-1], bus.op_b_i[W-1] ^ bus.op_i,
                   bus.op_a_i[W-2 -: EW], bus.op_b_i[W-2 -: EW],
                   expe_a, expe_b, sgf_a, sgf_b, cls_a, cls_b};

  ld_reg #(.WIDTH(S1W)) u_s1 (
    .clk  (clk),
    .rst  (rst),
    .load (s1_load),
    .d    (s1_d),
    .q    (s1_q)
  );

  // Stage 2: order operands and resolve special-case flags
  logic          r_swap, r_sa, r_sb;
  logic [EW-1:0] r_ea, r_eb, r_xa, r_xb;
  logic [SW:0]   r_ga, r_gb;
  logic [2:0]    r_ca, r_cb;
  cls_t          ca, cb;

  assign {r_swap, r_sa, r_sb, r_ea, r_eb, r_xa, r_xb, r_ga, r_gb, r_ca, r_cb} = s1_q;
  assign ca = cls_t'(r_ca);
  assign cb = cls_t'(r_cb);

  logic          eff_sub, sign_lg, zero_f, inf_f, nan_f;
  logic [EW-1:0] exp_lg, exp_diff;
  logic [SW:0]   sgf_lg, sgf_sm;
  logic [S2W-1:0] s2_d, s2_q;

  always_comb begin
    eff_sub  = r_sa ^ r_sb;
    sign_lg  = r_swap ? r_sb : r_sa;
    exp_lg   = r_swap ? r_eb : r_ea;
    exp_diff = r_swap ? (r_xb - r_xa) : (r_xa - r_xb);
    sgf_lg   = r_swap ? r_gb : r_ga;
    sgf_sm   = r_swap ? r_ga : r_gb;
    nan_f    = (ca == CLS_NAN) || (cb == CLS_NAN) ||
               ((ca == CLS_INF) && (cb == CLS_INF) && eff_sub);
    inf_f    = ((ca == CLS_INF) || (cb == CLS_INF)) && !nan_f;
    zero_f   = (ca == CLS_ZERO) && (cb == CLS_ZERO) && !nan_f && !inf_f;
  end

  assign s2_d = {sign_lg, exp_lg, exp_diff, sgf_lg, sgf_sm,
                 eff_sub, r_swap, zero_f, inf_f, nan_f};

  ld_reg #(.WIDTH(S2W)) u_s2 (
    .clk  (clk),
    .rst  (rst),
    .load (s2_load),
    .d    (s2_d),
    .q    (s2_q)
  );

  assign {bus.sign_lg_o, bus.exp_lg_o, bus.exp_diff_o, bus.sgf_lg_o, bus.sgf_sm_o,
          bus.eff_sub_o, bus.swap_o, bus.zero_o, bus.inf_o, bus.nan_o} = s2_q;
endmodule

// File: tb/tb_operand_unpack.sv
// Self-checking bench for operand_unpack (single precision) against an
// arithmetic reference model and a scoreboard queue.
module tb_operand_unpack;
  localparam int W  = 32;
  localparam int EW = 8;
  localparam int SW = 23;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_unpack_if #(.W(W), .EW(EW), .SW(SW)) bus ();

  operand_unpack #(.W(W), .EW(EW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          sign_lg;
    logic [EW-1:0] exp_lg;
    logic [EW-1:0] exp_diff;
    logic [SW:0]   sgf_lg;
    logic [SW:0]   sgf_sm;
    logic          eff_sub;
    logic          swap;
    logic          zero;
    logic          inf;
    logic          nan;
  } res_t;

  res_t exp_q[$];
  res_t obs;
  int   checks = 0;
  int   errors = 0;
  logic last_acc, last_emit, last_valid;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic res_t snap();
    return {bus.sign_lg_o, bus.exp_lg_o, bus.exp_diff_o, bus.sgf_lg_o, bus.sgf_sm_o,
            bus.eff_sub_o, bus.swap_o, bus.zero_o, bus.inf_o, bus.nan_o};
  endfunction

  // Reference: IEEE field rules evaluated with plain integer arithmetic.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t r;
    int ea, eb, xa, xb, d;
    logic [22:0] fa, fb;
    logic [SW:0] ga, gb;
    bit a_inf, b_inf, a_nan, b_nan, za, zb, sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0];        fb = b[22:0];
    a_inf = (ea == 255) && (fa == 0); a_nan = (ea == 255) && (fa != 0);
    b_inf = (eb == 255) && (fb == 0); b_nan = (eb == 255) && (fb != 0);
    ga = {ea != 0, fa}; gb = {eb != 0, fb};
    xa = ea; xb = eb;
    za = (ea == 0) && (fa == 0); zb = (eb == 0) && (fb == 0);
`ifdef OPERAND_UNPACK_DENORM_EN
    if (ea == 0) xa = 1;
    if (eb == 0) xb = 1;
`else
    if (ea == 0) begin ga = '0; za = 1; end
    if (eb == 0) begin gb = '0; zb = 1; end
`endif
    sb = b[31] ^ op;
    r.eff_sub = a[31] ^ sb;
    r.swap    = b[30:0] > a[30:0];
    if (r.swap) begin
      r.sign_lg = sb;    r.exp_lg = eb[7:0]; d = xb - xa; r.sgf_lg = gb; r.sgf_sm = ga;
    end else begin
      r.sign_lg = a[31]; r.exp_lg = ea[7:0]; d = xa - xb; r.sgf_lg = ga; r.sgf_sm = gb;
    end
    r.exp_diff = d[EW-1:0];
    r.nan  = a_nan || b_nan || (a_inf && b_inf && r.eff_sub);
    r.inf  = (a_inf || b_inf) && !r.nan;
    r.zero = za && zb && !r.nan && !r.inf;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom % 6)
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'h01;
      3: e = 8'hFE;
      default: e = 8'($urandom);
    endcase
    case ($urandom % 4)
      0: f = '0;
      1: f = 23'd1;
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One clock: observe handshake at the falling edge, score, then advance.
  task automatic tick();
    @(negedge clk);
    last_acc   = bus.valid_i && bus.ready_o;
    last_valid = bus.valid_o;
    last_emit  = bus.valid_o && bus.ready_i;
    obs        = snap();
    if (bus.valid_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", bus.valid_o, 0);
      end else begin
        chk("sign_lg",  obs.sign_lg,  exp_q[0].sign_lg);
        chk("exp_lg",   obs.exp_lg,   exp_q[0].exp_lg);
        chk("exp_diff", obs.exp_diff, exp_q[0].exp_diff);
        chk("sgf_lg",   obs.sgf_lg,   exp_q[0].sgf_lg);
        chk("sgf_sm",   obs.sgf_sm,   exp_q[0].sgf_sm);
        chk("eff_sub",  obs.eff_sub,  exp_q[0].eff_sub);
        chk("swap",     obs.swap,     exp_q[0].swap);
        chk("zero",     obs.zero,     exp_q[0].zero);
        chk("inf",      obs.inf,      exp_q[0].inf);
        chk("nan",      obs.nan,      exp_q[0].nan);
        if (bus.ready_i) void'(exp_q.pop_front());
      end
    end
    if (last_acc) exp_q.push_back(model(bus.op_a_i, bus.op_b_i, bus.op_i));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
    bus.valid_i = 1'b1; bus.op_a_i = a; bus.op_b_i = b; bus.op_i = op;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_valid) break;
    end
    chk("output_timeout", last_valid, 1);
  endtask

  logic [31:0] pa [5];
  logic [31:0] pb [5];
  int k;

  initial begin
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.op_i = 1'b0;
    bus.op_a_i = '0; bus.op_b_i = '0;
    #12;
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_outs_zero", |snap(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst", bus.ready_o, 1);
    bus.ready_i = 1'b1;

    // 1.0 + 2.0: B larger, two-cycle latency
    bus.valid_i = 1'b1; bus.op_a_i = 32'h3F800000; bus.op_b_i = 32'h40000000; bus.op_i = 1'b0;
    tick();
    chk("acc_first", last_acc, 1);
    bus.valid_i = 1'b0;
    tick();
    chk("latency_s1", last_valid, 0);
    tick();
    chk("latency_s2", last_valid, 1);
    chk("d1_swap", obs.swap, 1);
    chk("d1_exp_lg", obs.exp_lg, 8'h80);
    chk("d1_exp_diff", obs.exp_diff, 1);
    chk("d1_sgf_lg", obs.sgf_lg, 24'h800000);
    chk("d1_sgf_sm", obs.sgf_sm, 24'h800000);
    chk("d1_eff_sub", obs.eff_sub, 0);
    chk("d1_sign_lg", obs.sign_lg, 0);

    send(32'h7F800000, 32'h7F800000, 1'b1);
    wait_out();
    chk("inf_minus_inf_nan", obs.nan, 1);
    chk("inf_minus_inf_inf", obs.inf, 0);
    send(32'h7F800000, 32'h7F800000, 1'b0);
    wait_out();
    chk("inf_plus_inf_inf", obs.inf, 1);
    chk("inf_plus_inf_nan", obs.nan, 0);

    send(32'h00000001, 32'h00000000, 1'b0);
    wait_out();
`ifdef OPERAND_UNPACK_DENORM_EN
    chk("denorm_sgf_lg", obs.sgf_lg, 24'h000001);
    chk("denorm_exp_diff", obs.exp_diff, 0);
    chk("denorm_zero", obs.zero, 0);
`else
    chk("flush_zero", obs.zero, 1);
    chk("flush_sgf_lg", obs.sgf_lg, 0);
`endif

    send(32'hC0400000, 32'h40400000, 1'b0);
    wait_out();
    chk("tie_swap", obs.swap, 0);
    chk("tie_eff_sub", obs.eff_sub, 1);
    chk("tie_sign_lg", obs.sign_lg, 1);
    chk("tie_exp_diff", obs.exp_diff, 0);

    // Backpressure: five pairs offered with the sink stalled
    for (int i = 0; i < 5; i++) begin
      pa[i] = {1'($urandom), 8'(8'd1 + 8'($urandom % 250)), 23'($urandom)};
      pb[i] = {1'($urandom), 8'(8'd1 + 8'($urandom % 250)), 23'($urandom)};
    end
    bus.ready_i = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      bus.valid_i = 1'b1; bus.op_a_i = pa[k]; bus.op_b_i = pb[k]; bus.op_i = 1'($urandom);
      tick();
      if (last_acc) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_ready_low", bus.ready_o, 0);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (k < 5) begin
        bus.valid_i = 1'b1; bus.op_a_i = pa[k]; bus.op_b_i = pb[k];
      end else begin
        bus.valid_i = 1'b0;
      end
      tick();
      chk("bp_emit_consecutive", last_emit, 1);
      if (last_acc) k++;
    end
    bus.valid_i = 1'b0;
    chk("bp_all_accepted", k, 5);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset with two pairs in flight
    bus.ready_i = 1'b0;
    send(32'h40A00000, 32'h3F000000, 1'b0);
    send(32'hBF800000, 32'h41200000, 1'b1);
    chk("inflight_valid", bus.valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid_o", bus.valid_o, 0);
    chk("rst_async_outs_zero", |snap(), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_next_edge", bus.ready_o, 1);
    bus.ready_i = 1'b1;
    repeat (5) tick();

    // Random traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      bus.op_a_i = rand_op();
      bus.op_b_i = ($urandom % 4 == 0) ? {1'($urandom), bus.op_a_i[30:0]} : rand_op();
      bus.op_i    = 1'($urandom);
      bus.valid_i = ($urandom % 4) != 0;
      bus.ready_i = ($urandom % 4) != 0;
      tick();
    end

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
